instr_fetch_unit: RTL
=====================

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 Parameter HALT_ADDRESS, default 32'h00000000, fetch address that ends execution.
REQ-002 clk  input  1  system clock; single clock domain, all state updates on posedge clk.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on posedge clk.
REQ-004 pc_address  input  32  current fetch address from the program counter.
REQ-005 exec_stall  input  1  execute stage holds EXEC2, e.g. an outstanding data access.
REQ-006 waitrequest  input  1  memory bus stall for the current read.
REQ-007 readdata  input  32  memory bus read data, valid when read=1 and waitrequest=0.
REQ-008 address  output  32  memory bus word address.
REQ-009 read  output  1  memory bus read strobe.
REQ-010 byteenable  output  4  memory bus byte enables.
REQ-011 fetch, exec1, exec2  output  1 each  one-hot cycle-state strobes to the PC and datapath.
REQ-012 active  output  1  high until the CPU halts.
REQ-013 instr  output  32  latched instruction word.
REQ-014 offset  output  16  instr[15:0].
REQ-015 instr_index  output  26  instr[25:0].

Function
REQ-016 The FSM SHALL have exactly the states FETCH, EXEC1, EXEC2 and HALTED; fetch/exec1/exec2 SHALL be high only in the state of the same name.
REQ-017 In FETCH with pc_address != HALT_ADDRESS, the unit SHALL drive read=1, address=pc_address and byteenable=4'b1111.
REQ-018 In FETCH with waitrequest=1, the unit SHALL hold the state, address and read unchanged.
REQ-019 In FETCH with waitrequest=0, the unit SHALL capture readdata into instr at that edge and move to EXEC1.
REQ-020 EXEC1 SHALL move to EXEC2 unconditionally after one cycle.
REQ-021 EXEC2 SHALL move to FETCH when exec_stall=0 and hold EXEC2 while exec_stall=1.
REQ-022 In FETCH with pc_address == HALT_ADDRESS, the unit SHALL not assert read and SHALL move to HALTED at the next edge.
REQ-023 HALTED SHALL be absorbing until reset, with active=0, read=0 and all state strobes 0.
REQ-024 Outside FETCH, read SHALL be 0, byteenable SHALL be 4'b0000, and address SHALL hold its last fetch value.
REQ-025 instr SHALL change only at a completing FETCH edge and SHALL remain stable through EXEC1 and EXEC2.
REQ-026 offset and instr_index SHALL be combinational slices of the latched instr.
REQ-027 When waitrequest deasserts in the same cycle that pc_address equals HALT_ADDRESS, the halt condition SHALL take priority and the readdata SHALL be ignored.

Reset
REQ-028 reset=1 SHALL force state FETCH, instr=0 and address=0 at the next edge, overriding any state including a stalled FETCH and HALTED.
REQ-029 In the cycle after reset deasserts, the unit SHALL be in FETCH with active=1, and read SHALL follow REQ-017.

Configuration
REQ-030 With INSTR_BYTESWAP_EN defined, instr SHALL capture {readdata[7:0], readdata[15:8], readdata[23:16], readdata[31:24]}, converting the little-endian bus to big-endian MIPS order.
REQ-031 Without INSTR_BYTESWAP_EN, instr SHALL capture readdata unchanged.

Structure
REQ-032 The state enum (FETCH, EXEC1, EXEC2, HALTED) and the default halt-address constant SHALL live in the shared CPU package, also imported by the PC and the datapath.
REQ-033 The byte-swap SHALL be a separate sub-module, endian_swap, instantiated only under INSTR_BYTESWAP_EN.
REQ-034 There SHALL be no other sub-modules.

Verification
REQ-035 Reset, then pc_address=32'hBFC00000, waitrequest=0, readdata=32'h8C220004 -> read=1, address=32'hBFC00000; next cycle exec1=1 and instr=32'h8C220004 (32'h0400228C with the macro); following cycle exec2=1.
REQ-036 waitrequest=1 for 3 cycles in FETCH -> fetch, read and address held for 3 cycles; instr captured on the 4th edge.
REQ-037 exec_stall=1 for 2 cycles in EXEC2 -> exec2 held for 3 cycles total, then fetch=1.
REQ-038 pc_address=0 in FETCH -> read never asserted; next cycle active=0 and all strobes 0; state stays HALTED for 10 cycles.
REQ-039 reset asserted mid-FETCH with waitrequest=1, and separately from HALTED -> next cycle fetch=1, active=1, instr=0.
REQ-040 instr=32'h1000FFFF -> offset=16'hFFFF and instr_index=26'h000FFFF.

Source files
------------

// File: rtl/instr_fetch_unit_pkg.sv
// Shared CPU package: cycle-state encoding and default halt address,
// imported by the fetch unit, PC and datapath.
package instr_fetch_unit_pkg;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    EXEC1  = 2'd1,
    EXEC2  = 2'd2,
    HALTED = 2'd3
  } cpu_state_t;

  localparam logic [31:0] DEFAULT_HALT_ADDRESS = 32'h0000_0000;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction memory bus (Avalon-style read port) between the fetch unit
// and instruction memory.
interface instr_fetch_unit_if;

  logic [31:0] address;
  logic        read;
  logic [3:0]  byteenable;
  logic        waitrequest;
  logic [31:0] readdata;

  modport master (
    output address, read, byteenable,
    input  waitrequest, readdata
  );

  modport slave (
    input  address, read, byteenable,
    output waitrequest, readdata
  );

endinterface

// File: rtl/instr_fetch_unit_endian_swap.sv
// Byte reversal of a 32-bit word: little-endian bus order to big-endian
// MIPS instruction order.
module endian_swap (
  input  logic [31:0] i_data,
  output logic [31:0] o_data
);

  assign o_data = {i_data[7:0], i_data[15:8], i_data[23:16], i_data[31:24]};

endmodule

// File: rtl/instr_fetch_unit.sv
// Multi-cycle CPU instruction fetch unit: FETCH/EXEC1/EXEC2/HALTED sequencer
// with instruction latch. Define INSTR_BYTESWAP_EN to byte-swap fetched words.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter logic [31:0] HALT_ADDRESS = DEFAULT_HALT_ADDRESS
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [31:0]         pc_address,
  input  logic                exec_stall,
  instr_fetch_unit_if.master  bus,
  output logic                fetch,
  output logic                exec1,
  output logic                exec2,
  output logic                active,
  output logic [31:0]         instr,
  output logic [15:0]         offset,
  output logic [25:0]         instr_index
);

  cpu_state_t  r_state;
  cpu_state_t  w_next;
  logic [31:0] r_instr;
  logic [31:0] r_address;
  logic [31:0] w_fetchWord;
  logic        w_isHalt;
  logic        w_capture;

  assign w_isHalt = (pc_address == HALT_ADDRESS);

`ifdef INSTR_BYTESWAP_EN
  endian_swap u_endian_swap (
    .i_data (bus.readdata),
    .o_data (w_fetchWord)
  );
`else
  assign w_fetchWord = bus.readdata;
`endif

  always_comb begin
    w_next         = r_state;
    w_capture      = 1'b0;
    fetch          = 1'b0;
    exec1          = 1'b0;
    exec2          = 1'b0;
    active         = (r_state != HALTED);
    bus.read       = 1'b0;
    bus.byteenable = 4'b0000;
    bus.address    = r_address;
    case (r_state)
      FETCH: begin
        fetch = 1'b1;
        // Halt wins over a completing read: the returned word is dropped.
        if (w_isHalt) begin
          w_next = HALTED;
        end else begin
          bus.read       = 1'b1;
          bus.byteenable = 4'b1111;
          bus.address    = pc_address;
          if (!bus.waitrequest) begin
            w_capture = 1'b1;
            w_next    = EXEC1;
          end
        end
      end
      EXEC1: begin
        exec1  = 1'b1;
        w_next = EXEC2;
      end
      EXEC2: begin
        exec2 = 1'b1;
        if (!exec_stall) w_next = FETCH;
      end
      HALTED: w_next = HALTED;
      default: w_next = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= FETCH;
      r_instr   <= 32'h0;
      r_address <= 32'h0;
    end else begin
      r_state <= w_next;
      // Remember the last driven fetch address so it holds outside FETCH.
      if (r_state == FETCH && !w_isHalt) r_address <= pc_address;
      if (w_capture) r_instr <= w_fetchWord;
    end
  end

  assign instr       = r_instr;
  assign offset      = r_instr[15:0];
  assign instr_index = r_instr[25:0];

endmodule
